// File: rtl/config_chain_driver.sv
// Config chain driver: serializes valid/ready words MSB-first onto the tile
// shift chain, then pulses set. Ports: clk/rst, cfg_* stream, chain_* to
// tiles, busy/done status, rb_* readback (built only with CFG_READBACK_EN).
module config_chain_driver #(
  parameter int DW    = 32,
  parameter int CNT_W = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] cfg_data,
  input  logic          cfg_last,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic          chain_shift_out,
  output logic          chain_cen,
  output logic          chain_set,
  input  logic          chain_shift_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rb_data,
  output logic          rb_valid
);

  typedef enum logic [1:0] {IDLE, SHIFT, SET} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              cen_q, cen_d;
  logic              so_q, so_d;
  logic              set_q, set_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              cnt_zero;
  logic              xfer;

  assign cnt_zero = (cnt_q == '0);
  assign xfer     = cfg_valid && cfg_ready;

  always_comb begin
    cfg_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    cfg_ready = 1'b1;
        SHIFT:   cfg_ready = cnt_zero && !last_q;
        default: cfg_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      cen_q   <= 1'b0;
      so_q    <= 1'b0;
      set_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cen_q   <= cen_d;
      so_q    <= so_d;
      set_q   <= set_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (xfer) state_d = SHIFT;
      SHIFT:
        if (cnt_zero) begin
          if (last_q)     state_d = SET;
          else if (!xfer) state_d = IDLE;
        end
      SET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: this computes the values they take next cycle.
  // The bit on the wire this cycle lives in so_q, sreg_q holds the rest.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    cen_d  = 1'b0;
    so_d   = 1'b0;
    set_d  = 1'b0;
    done_d = 1'b0;
    busy_d = busy_q;
    if (xfer) begin
      sreg_d = {cfg_data[DW-2:0], 1'b0};
      so_d   = cfg_data[DW-1];
      cen_d  = 1'b1;
      cnt_d  = CNT_W'(DW-1);
      last_d = cfg_last;
      busy_d = 1'b1;
    end else begin
      unique case (state_q)
        SHIFT:
          if (!cnt_zero) begin
            so_d   = sreg_q[DW-1];
            sreg_d = {sreg_q[DW-2:0], 1'b0};
            cnt_d  = cnt_q - 1'b1;
            cen_d  = 1'b1;
          end else if (last_q) begin
            set_d = 1'b1;
          end
        SET: begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign chain_cen       = cen_q;
  assign chain_shift_out = so_q;
  assign chain_set       = set_q;
  assign done            = done_q;
  assign busy            = busy_q;

`ifdef CFG_READBACK_EN
  logic [DW-1:0]    rb_sreg_q;
  logic [DW-1:0]    rb_data_q;
  logic [CNT_W-1:0] rb_cnt_q;
  logic             rb_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_sreg_q  <= '0;
      rb_data_q  <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      if (cen_q) begin
        rb_sreg_q <= {rb_sreg_q[DW-2:0], chain_shift_in};
        if (rb_cnt_q == CNT_W'(DW-1)) begin
          rb_cnt_q   <= '0;
          rb_data_q  <= {rb_sreg_q[DW-2:0], chain_shift_in};
          rb_valid_q <= 1'b1;
        end else begin
          rb_cnt_q <= rb_cnt_q + 1'b1;
        end
      end
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_rb;
  assign unused_rb = chain_shift_in;
  assign rb_data   = '0;
  assign rb_valid  = 1'b0;
`endif

endmodule

// File: doc/config_chain_driver.md
# config_chain_driver

Drives the configuration shift chain that runs through the fabric tiles. It accepts configuration words on a valid/ready stream and serializes them MSB-first onto the chain's serial input, asserting the chain's shift enable. After the final word it issues a single-cycle set pulse so every tile latches its shifted configuration. It sits between the chip-level configuration port and the first tile's `shift_in`; the last tile's `shift_out` returns to it for optional readback.

## Interface

- `DW`, 32, configuration word width in bits (≥2)
- `CNT_W`, `$clog2(DW)`, bit-counter width

- `clk`  input  1  clock
- `rst`  input  1  synchronous reset, active-high
- `cfg_data`  input  DW  configuration word, bit DW-1 shifted first
- `cfg_last`  input  1  qualifies `cfg_data` as the final word of a frame
- `cfg_valid`  input  1  word available
- `cfg_ready`  output  1  driver accepts word this cycle
- `chain_shift_out`  output  1  serial data to first tile's `shift_in`
- `chain_cen`  output  1  shift enable to all tiles
- `chain_set`  output  1  set pulse to all tiles (`set_in`)
- `chain_shift_in`  input  1  serial data from last tile's `shift_out`
- `busy`  output  1  frame in progress (first accept through set)
- `done`  output  1  one-cycle pulse after set
- `rb_data`  output  DW  readback word (macro-gated, see Configuration)
- `rb_valid`  output  1  readback word valid pulse (macro-gated)

## Operation

- Handshake: word transfers on a rising edge where `cfg_valid && cfg_ready`.
- States: IDLE, SHIFT, SET.
- IDLE: `cfg_ready=1`, `chain_cen=0`. On transfer: load shift register, latch `cfg_last` into `last_q`, counter ← DW-1, `busy`←1, → SHIFT.
- SHIFT: `chain_cen=1`, `chain_shift_out = sreg[DW-1]`; each cycle sreg ← sreg<<1, counter −1.
  - counter ≠ 0: `cfg_ready=0`.
  - counter == 0, `last_q=0`: `cfg_ready=1`; transfer → reload, stay SHIFT (gapless); no transfer → IDLE with `busy` held 1.
  - counter == 0, `last_q=1`: `cfg_ready=0`, → SET.
- SET: `chain_set=1` for exactly one cycle, `chain_cen=0`; → IDLE, `busy`←0, `done`=1 next cycle.
- Words between frames: the first word accepted with `busy=0` starts a frame; no set is issued until a `cfg_last` word completes.
- `chain_cen`, `chain_shift_out`, `chain_set`, `done`, `busy` are registered outputs; `cfg_ready` is combinational from state/counter and forced 0 while `rst=1`.
- Reset (including mid-frame): state → IDLE, counter 0, sreg 0, `last_q` 0; all outputs 0 in the cycle after `rst` sampled high. An aborted frame never produces `chain_set`; tile contents are then undefined until a full frame is reloaded.

## Timing

- Transfer at edge N → first bit on `chain_shift_out` with `chain_cen=1` during cycle N+1.
- One word = DW consecutive `chain_cen` cycles.
- Back-to-back words: next word accepted on last bit's cycle; `chain_cen` stays high without gap.
- Final bit in cycle M → `chain_set=1` in cycle M+1 → `done=1` in cycle M+2, `busy=0` from M+2.
- Minimum frame of k words: k·DW + 2 cycles from first transfer to `done`.

## Configuration

- `CFG_READBACK_EN` defined: `chain_shift_in` sampled on every cycle with `chain_cen=1`, shifted into `rb_sreg` (LSB entry); after each DW samples, `rb_data` ← assembled word and `rb_valid=1` for one cycle, registered, coincident with the cycle after the word's last shift. No backpressure; consumer must take it. Reset clears `rb_data`, `rb_valid`, sample counter.
- Not defined: `rb_data` tied 0, `rb_valid` tied 0, `chain_shift_in` ignored, no readback logic.

## Test plan

- DW=8, single word 0xA5 with `cfg_last=1` → `chain_shift_out` 1,0,1,0,0,1,0,1 over 8 `chain_cen` cycles, `chain_set` next cycle, `done` one cycle later.
- Words 0xFF then 0x00(last), `cfg_valid` held → 16 contiguous `chain_cen` cycles, `cfg_ready` high only on cycles 0 and 8, exactly one `chain_set`.
- `cfg_valid` dropped for 5 cycles between word 1 and word 2(last) → `chain_cen` low 5 cycles, `busy` stays 1, no `chain_set` before word 2 completes.
- `rst` pulsed after 3 bits of 0xA5(last) → next cycle all outputs 0, no `chain_set`/`done`; new frame then runs normally.
- `CFG_READBACK_EN`, chain modeled as 8-bit shift register preloaded 0x3C, load 0x81(last) → `rb_valid` pulse with `rb_data=0x3C`; model holds 0x81 at `chain_set`.
- Without macro → `rb_valid` never asserts for any stimulus.
